add_result_stage: RTL and testbench
===================================

# add_result_stage

Registered output stage directly downstream of the 64-bit signed CLA adder (`ADD`). It captures `out`, `carry_out` and `overflow_check` through a valid/ready handshake in a 2-entry skid buffer. It optionally saturates overflowed sums to the signed limits and keeps a saturating count of overflow events for status readout.

## Interface
- `WIDTH`, 64: data width; must match the adder's `out` width.
- `SATURATE`, 1: 1 = replace an overflowed sum with the signed limit; 0 = pass the wrapped sum unchanged.
- `CNT_W`, 16: width of the overflow event counter.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  adder result is valid this cycle.
- `in_ready`  out  1  stage can accept a beat.
- `sum`  in  WIDTH  signed adder result (`ADD.out`).
- `carry_in_flag`  in  1  `ADD.carry_out`.
- `ovf_in`  in  1  `ADD.overflow_check`.
- `out_valid`  out  1  `result` holds a valid beat.
- `out_ready`  in  1  consumer accepts the beat.
- `result`  out  WIDTH  registered signed result, saturated if enabled.
- `result_carry`  out  1  carry of the beat on `result`.
- `result_ovf`  out  1  overflow flag of the beat on `result`; set even when saturated.
- `ovf_count`  out  CNT_W  number of accepted beats with `ovf_in`=1; saturates at all-ones.
- `ovf_count_clr`  in  1  synchronous clear of `ovf_count`.

## Operation
- Accept: `in_valid && in_ready`. Deliver: `out_valid && out_ready`.
- Storage: 2 entries. Each entry holds {data, carry, ovf}.
- Buffer states:
  - EMPTY(0): `in_ready`=1, `out_valid`=0.
  - ONE(1): `in_ready`=1, `out_valid`=1.
  - FULL(2): `in_ready`=0, `out_valid`=1.
- Transitions:
  - EMPTY → ONE on accept.
  - ONE → FULL on accept without deliver.
  - ONE → EMPTY on deliver without accept.
  - ONE stays ONE on simultaneous accept and deliver; the new beat replaces the delivered one.
  - FULL → ONE on deliver; no accept is possible while FULL.
- Ordering: strictly FIFO. No beat is dropped or duplicated.
- Saturation (`SATURATE`=1, `ovf_in`=1):
  - True sign = ~`sum[WIDTH-1]`.
  - `sum[WIDTH-1]`=1 → result 0x7FFF_FFFF_FFFF_FFFF.
  - `sum[WIDTH-1]`=0 → result 0x8000_0000_0000_0000.
  - `result_carry` always passes through unmodified.
- Counter:
  - Increments on each accept with `ovf_in`=1.
  - Holds at 2^CNT_W−1; does not wrap.
  - `ovf_count_clr` alone → 0.
  - `ovf_count_clr` together with a counting accept → 1 (the event is not lost).
- `in_ready` and `out_valid` are driven from registered state only; no combinational path from `out_ready`.

## Timing
- Latency: a beat accepted at edge N appears on `result` with `out_valid`=1 after edge N. It is deliverable in cycle N+1 if the buffer was EMPTY.
- Throughput: one beat per cycle while `out_ready`=1.
- Backpressure: `in_ready` falls one cycle after the second un-drained beat is accepted.
- Reset, applied immediately and asynchronously:
  - `in_ready`=1 after reset releases.
  - `out_valid`=0.
  - `result`=0, `result_carry`=0, `result_ovf`=0.
  - `ovf_count`=0; buffer state EMPTY.
- Reset during a transfer discards all buffered beats.
- `result` is held stable while `out_valid`=1 and `out_ready`=0.

## Structure
- Shared package `add_pkg`:
  - `ADD_WIDTH` = 64.
  - `SAT_MAX`, `SAT_MIN` constants.
  - Buffer state enum {EMPTY, ONE, FULL}.
  - Entry struct {data, carry, ovf}.
- One combinational sub-module, `add_sat`: (`sum`, `ovf_in`) → saturated data, instantiated on the input side before storage.
- The 2-entry buffer and the counter stay in the top module.

## Test plan
- Single beat: `sum`=5, `ovf_in`=0, `out_ready`=1 → `result`=5, `out_valid` for one cycle, `ovf_count`=0.
- Positive overflow: 0x7FFF_FFFF_FFFF_FFFF + 1 gives `sum`=0x8000_0000_0000_0000 with `ovf_in`=1.
  - `SATURATE`=1 → `result`=0x7FFF_FFFF_FFFF_FFFF, `result_ovf`=1, `ovf_count`=1.
  - `SATURATE`=0 → `result`=0x8000_0000_0000_0000.
- Negative overflow: `sum`=0x7FFF_FFFF_FFFF_FFFF with `ovf_in`=1 → `result`=0x8000_0000_0000_0000.
- Backpressure: hold `out_ready`=0 and send 1, 2, 3 back-to-back → `in_ready`=0 after 2 accepts. Release `out_ready` → outputs 1, 2, then 3, in order, with no loss.
- Counter edges:
  - Preload to 0xFFFF (CNT_W=16), then send another overflow → stays 0xFFFF.
  - Clear together with an overflow accept → 1.
- Reset mid-stream with the buffer FULL → `out_valid`=0 and `ovf_count`=0 immediately. First beat after release is accepted normally.

Source files
------------

// File: rtl/add_pkg.sv
// Shared definitions for the adder result stage.
//   ADD_WIDTH : data width of the upstream signed CLA adder output.
//   SAT_MAX / SAT_MIN : signed limits substituted for an overflowed sum.
//   buf_state_e : occupancy of the 2-entry output skid buffer.
//   entry_t : one buffered beat {data, carry, ovf}.
package add_pkg;

  localparam int unsigned ADD_WIDTH = 64;

  localparam logic [ADD_WIDTH-1:0] SAT_MAX = {1'b0, {(ADD_WIDTH-1){1'b1}}};
  localparam logic [ADD_WIDTH-1:0] SAT_MIN = {1'b1, {(ADD_WIDTH-1){1'b0}}};

  // Encodings equal the number of beats held.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [ADD_WIDTH-1:0] data;
    logic                 carry;
    logic                 ovf;
  } entry_t;

endpackage

// File: rtl/add_sat.sv
// Combinational saturation of the adder sum.
//   sum    : signed adder result
//   ovf_in : adder signalled signed overflow
//   data   : sum, or the signed limit matching the true sign when overflowed
//            and SATURATE is set
module add_sat
  import add_pkg::*;
#(
  parameter bit SATURATE = 1'b1
) (
  input  logic [ADD_WIDTH-1:0] sum,
  input  logic                 ovf_in,
  output logic [ADD_WIDTH-1:0] data
);

  always_comb begin
    data = sum;
    // On overflow the true sign is the inverse of the wrapped sign bit.
    if (SATURATE && ovf_in) begin
      data = sum[ADD_WIDTH-1] ? SAT_MAX : SAT_MIN;
    end
  end

endmodule

// File: rtl/add_result_stage.sv
// Registered output stage behind the 64-bit signed adder.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid / in_ready   : upstream handshake
//   sum, carry_in_flag, ovf_in : adder out, carry_out, overflow_check
//   out_valid / out_ready : downstream handshake
//   result, result_carry, result_ovf : head beat of the 2-entry buffer
//   ovf_count, ovf_count_clr : saturating overflow-event counter and its clear
module add_result_stage
  import add_pkg::*;
#(
  parameter int unsigned WIDTH    = ADD_WIDTH,
  parameter bit          SATURATE = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum,
  input  logic             carry_in_flag,
  input  logic             ovf_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_carry,
  output logic             result_ovf,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             ovf_count_clr
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  buf_state_e       state_q, state_d;
  entry_t           head_q, head_d;
  entry_t           skid_q, skid_d;
  entry_t           in_entry;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sat_data;
  logic             accept, deliver, count_inc;

  add_sat #(
    .SATURATE(SATURATE)
  ) u_add_sat (
    .sum    (sum),
    .ovf_in (ovf_in),
    .data   (sat_data)
  );

  // Handshake outputs come straight from the state register.
  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;
  assign count_inc = accept && ovf_in;

  always_comb begin
    in_entry       = '0;
    in_entry.data  = sat_data;
    in_entry.carry = carry_in_flag;
    in_entry.ovf   = ovf_in;
  end

  // head_q is always the oldest beat; skid_q only holds a beat while FULL.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          head_d  = in_entry;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && deliver) begin
          head_d = in_entry;
        end else if (accept) begin
          skid_d  = in_entry;
          state_d = StFull;
        end else if (deliver) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (deliver) begin
          head_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // A clear coinciding with a counted accept keeps that event.
  always_comb begin
    cnt_d = cnt_q;
    if (ovf_count_clr) begin
      cnt_d = count_inc ? CNT_ONE : '0;
    end else if (count_inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      head_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign result       = head_q.data;
  assign result_carry = head_q.carry;
  assign result_ovf   = head_q.ovf;
  assign ovf_count    = cnt_q;

endmodule

// File: tb/tb_add_result_stage.sv
module tb_add_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] sum;
  logic        carry_in_flag;
  logic        ovf_in;
  logic        out_ready;
  logic        ovf_count_clr;

  logic        in_ready, out_valid, result_carry, result_ovf;
  logic [63:0] result;
  logic [15:0] ovf_count;

  logic        ns_in_ready, ns_out_valid, ns_result_carry, ns_result_ovf;
  logic [63:0] ns_result;
  logic [15:0] ns_ovf_count;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  add_result_stage #(.WIDTH(64), .SATURATE(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sum(sum),
    .carry_in_flag(carry_in_flag), .ovf_in(ovf_in), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .result_carry(result_carry),
    .result_ovf(result_ovf), .ovf_count(ovf_count), .ovf_count_clr(ovf_count_clr)
  );

  add_result_stage #(.WIDTH(64), .SATURATE(1'b0), .CNT_W(16)) dut_ns (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ns_in_ready), .sum(sum),
    .carry_in_flag(carry_in_flag), .ovf_in(ovf_in), .out_valid(ns_out_valid),
    .out_ready(out_ready), .result(ns_result), .result_carry(ns_result_carry),
    .result_ovf(ns_result_ovf), .ovf_count(ns_ovf_count), .ovf_count_clr(ovf_count_clr)
  );

  // Present one beat for exactly one edge; caller is at posedge+1 with in_ready=1.
  task automatic push(input logic [63:0] s, input logic c, input logic o);
    in_valid = 1'b1; sum = s; carry_in_flag = c; ovf_in = o;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; sum = '0; carry_in_flag = 1'b0; ovf_in = 1'b0;
    out_ready = 1'b0; ovf_count_clr = 1'b0;
    #3;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
    total++; if (result !== 64'h0) $display("FAIL reset_result: got %h want 0", result); else passed++;
    total++; if ({result_carry, result_ovf} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {result_carry, result_ovf}); else passed++;
    total++; if (ovf_count !== 16'h0) $display("FAIL reset_count: got %h want 0", ovf_count); else passed++;
    #10 rst = 1'b0;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL post_reset_hs: got ready=%b valid=%b want 1/0", in_ready, out_valid); else passed++;
  endtask

  task automatic test_single;
    out_ready = 1'b1;
    push(64'd5, 1'b1, 1'b0);
    total++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", out_valid); else passed++;
    total++; if (result !== 64'd5) $display("FAIL single_result: got %h want 5", result); else passed++;
    total++; if (result_carry !== 1'b1 || result_ovf !== 1'b0) $display("FAIL single_flags: got c=%b o=%b want 1/0", result_carry, result_ovf); else passed++;
    total++; if (ovf_count !== 16'h0) $display("FAIL single_count: got %h want 0", ovf_count); else passed++;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) $display("FAIL single_drained: got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_pos_ovf;
    out_ready = 1'b1;
    push(64'h8000_0000_0000_0000, 1'b0, 1'b1);
    total++; if (result !== 64'h7FFF_FFFF_FFFF_FFFF) $display("FAIL pos_sat_result: got %h want 7fffffffffffffff", result); else passed++;
    total++; if (result_ovf !== 1'b1) $display("FAIL pos_sat_ovf: got %b want 1", result_ovf); else passed++;
    total++; if (ovf_count !== 16'd1) $display("FAIL pos_sat_count: got %h want 1", ovf_count); else passed++;
    total++; if (ns_result !== 64'h8000_0000_0000_0000) $display("FAIL pos_nosat_result: got %h want 8000000000000000", ns_result); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_neg_ovf;
    out_ready = 1'b1;
    push(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    total++; if (result !== 64'h8000_0000_0000_0000) $display("FAIL neg_sat_result: got %h want 8000000000000000", result); else passed++;
    total++; if (result_carry !== 1'b1) $display("FAIL neg_sat_carry: got %b want 1", result_carry); else passed++;
    total++; if (ovf_count !== 16'd2) $display("FAIL neg_sat_count: got %h want 2", ovf_count); else passed++;
    total++; if (ns_result !== 64'h7FFF_FFFF_FFFF_FFFF) $display("FAIL neg_nosat_result: got %h want 7fffffffffffffff", ns_result); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    in_valid = 1'b1; sum = 64'd1; carry_in_flag = 1'b0; ovf_in = 1'b0;
    @(posedge clk); #1;
    sum = 64'd2;
    @(posedge clk); #1;
    sum = 64'd3;
    total++; if (in_ready !== 1'b0) $display("FAIL bp_full_ready: got %b want 0", in_ready); else passed++;
    total++; if (out_valid !== 1'b1 || result !== 64'd1) $display("FAIL bp_full_head: got v=%b r=%h want 1/1", out_valid, result); else passed++;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b0 || result !== 64'd1) $display("FAIL bp_hold: got rdy=%b r=%h want 0/1", in_ready, result); else passed++;
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL bp_no_comb_path: got %b want 0", in_ready); else passed++;
    @(posedge clk); #1;
    total++; if (result !== 64'd2 || in_ready !== 1'b1) $display("FAIL bp_out2: got r=%h rdy=%b want 2/1", result, in_ready); else passed++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (result !== 64'd3 || out_valid !== 1'b1) $display("FAIL bp_out3: got r=%h v=%b want 3/1", result, out_valid); else passed++;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) $display("FAIL bp_drained: got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_counter;
    out_ready = 1'b1;
    ovf_count_clr = 1'b1;
    @(posedge clk); #1;
    ovf_count_clr = 1'b0;
    total++; if (ovf_count !== 16'h0) $display("FAIL cnt_clear: got %h want 0", ovf_count); else passed++;
    in_valid = 1'b1; sum = 64'h0; carry_in_flag = 1'b0; ovf_in = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++; if (ovf_count !== 16'hFFFF) $display("FAIL cnt_max: got %h want ffff", ovf_count); else passed++;
    push(64'h0, 1'b0, 1'b1);
    total++; if (ovf_count !== 16'hFFFF) $display("FAIL cnt_hold: got %h want ffff", ovf_count); else passed++;
    ovf_count_clr = 1'b1;
    push(64'h0, 1'b0, 1'b1);
    ovf_count_clr = 1'b0;
    total++; if (ovf_count !== 16'd1) $display("FAIL cnt_clr_with_ovf: got %h want 1", ovf_count); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    push(64'd7, 1'b0, 1'b1);
    push(64'd8, 1'b0, 1'b1);
    total++; if (in_ready !== 1'b0 || ovf_count !== 16'd3) $display("FAIL rm_full: got rdy=%b cnt=%h want 0/3", in_ready, ovf_count); else passed++;
    #3 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || ovf_count !== 16'h0) $display("FAIL rm_async: got v=%b cnt=%h want 0/0", out_valid, ovf_count); else passed++;
    total++; if (in_ready !== 1'b1 || result !== 64'h0) $display("FAIL rm_state: got rdy=%b r=%h want 1/0", in_ready, result); else passed++;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    push(64'd9, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b1 || result !== 64'd9) $display("FAIL rm_after: got v=%b r=%h want 1/9", out_valid, result); else passed++;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) $display("FAIL rm_no_stale: got %b want 0", out_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_pos_ovf();
    test_neg_ovf();
    test_backpressure();
    test_counter();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
